bit_serial_add_ctrl: RTL and testbench

//   Sequencer for a bit-serial adder. Accepts two WIDTH-bit operands and feeds them LSB-first

---
 rtl/bit_serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder sequencer: operands go LSB-first through one full-adder slice with a registered carry.
// Optional SUB_MODE_EN adds a 'sub' port (A-B via inverted B and initial carry of 1).
module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             b_bit;
    logic             s_bit;
    logic             c_nxt;
`ifdef SUB_MODE_EN
    logic             sub_r;
`endif

    always_comb begin
        b_bit = b_sh[0];
`ifdef SUB_MODE_EN
        b_bit = b_sh[0] ^ sub_r;
`endif
        s_bit = a_sh[0] ^ b_bit ^ carry;
        c_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry) | (b_bit & carry);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
            carry   <= 1'b0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
`ifdef SUB_MODE_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SUB_MODE_EN
                        sub_r <= sub;
                        carry <= sub;
`else
                        carry <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    carry  <= c_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    // Last bit: publish the sum including the bit computed this cycle.
                    if (cnt == LAST_BIT) begin
                        sum_out <= {s_bit, sum_sh[WIDTH-1:1]};
                        c_out   <= c_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed, table-driven bench for bit_serial_add_ctrl (WIDTH=8); SUB_MODE_EN adds subtract vectors.
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;

    int total;
    int bad;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
`ifdef SUB_MODE_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sb;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one operation and follows it to done; all sampling on negedges.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        bit overlap;
        @(negedge clock);
        a_in  = v.a;
        b_in  = v.b;
        sub   = v.sb;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a_in  = ~v.a;
        b_in  = ~v.b;
        lat      = 21;
        busy_cnt = 0;
        overlap  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clock);
        end
        chk({tag, " latency"}, 32'(lat), 32'd9);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, " sum_out"}, 32'(sum_out), 32'(v.exp_sum));
        chk({tag, " c_out"}, 32'(c_out), 32'(v.exp_c));
        chk({tag, " busy_and_done"}, 32'(overlap), 32'd0);
        @(negedge clock);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " sum_held"}, 32'(sum_out), 32'(v.exp_sum));
    endtask

    initial begin
        int done_cnt;
        int t1;
        int t2;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic c1;
        logic c2;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        sub   = 1'b0;

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'hC3, 8'h7E, 1'b0, 8'h41, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
`ifdef SUB_MODE_EN
        vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h37, 8'h37, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
`endif

        repeat (2) @(negedge clock);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum_out", 32'(sum_out), 32'd0);
        chk("reset c_out", 32'(c_out), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // start pulsed mid-SHIFT with other operands must be ignored
        @(negedge clock);
        a_in = 8'h5A; b_in = 8'h3C; sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        a_in = 8'h11; b_in = 8'h22; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                done_cnt++;
                chk("ignore sum_out", 32'(sum_out), 32'h96);
                chk("ignore c_out", 32'(c_out), 32'd0);
            end
            @(negedge clock);
        end
        chk("ignore done_count", 32'(done_cnt), 32'd1);

        // reset in the middle of SHIFT aborts the operation
        @(negedge clock);
        a_in = 8'hFF; b_in = 8'h01; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum_out", 32'(sum_out), 32'd0);
        chk("abort c_out", 32'(c_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("abort no_activity", 32'(done_cnt), 32'd0);

        // start held high: back-to-back results WIDTH+1 cycles apart
        @(negedge clock);
        a_in = 8'h01; b_in = 8'h01; sub = 1'b0; start = 1'b1;
        @(negedge clock);
        a_in = 8'h80; b_in = 8'h80;
        t1 = -1; t2 = -1;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = k; s1 = sum_out; c1 = c_out;
                end else if (t2 < 0) begin
                    t2 = k; s2 = sum_out; c2 = c_out;
                end
            end
            if (t1 >= 0 && k == t1 + 1) start = 1'b0;
            @(negedge clock);
        end
        chk("b2b first_latency", 32'(t1), 32'd9);
        chk("b2b spacing", 32'(t2 - t1), 32'd9);
        chk("b2b sum1", 32'(s1), 32'h02);
        chk("b2b c1", 32'(c1), 32'd0);
        chk("b2b sum2", 32'(s2), 32'h00);
        chk("b2b c2", 32'(c2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
